wordline_regfile: RTL
=====================

# wordline_regfile

Register-file storage block for the 16-entry register file. It accepts writes as a one-hot 16-bit wordline, the output format of the 4-to-16 write decoder, and serves two read ports addressed by 4-bit register IDs. Those IDs are decoded internally into one-hot readlines, which is the read direction of the same bitcell array. It also encodes each accepted wordline back into a register index and flags malformed, multi-hot wordlines. It sits between the write-back stage, which drives the wordline and write data, and the decode stage, which issues read IDs and consumes the read data.

## Interface
- DATA_W, 16, width of each register and of all data ports
- BYPASS, 1, 1 = a same-cycle write to a read register forwards DstData to the read port; 0 = the read returns the stored (old) value
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low; one clock; reset is asynchronous and active-low
- Wordline  in  16  one-hot write select; bit i writes register i; all-zero means no write
- DstData  in  DATA_W  write data
- SrcReg1  in  4  read port 1 register ID
- SrcReg2  in  4  read port 2 register ID
- SrcData1  out  DATA_W  read port 1 data (combinational)
- SrcData2  out  DATA_W  read port 2 data (combinational)
- WrValid  out  1  registered; high for exactly one cycle after each accepted write
- LastWrId  out  4  registered; encoded index of the most recent accepted write
- WlError  out  1  registered, sticky; set by a multi-hot Wordline

## Operation
- **Storage:** 16 registers of DATA_W bits. All 16 are writable; none is hardwired to zero.
- **Wordline classification** (combinational, every cycle), by popcount of Wordline:
  - 0: idle; no state change except WrValid is cleared.
  - 1: accepted write. At the clock edge, register[i] <= DstData, LastWrId <= i, WrValid <= 1.
  - 2 or more: rejected. No register is written, LastWrId holds, WrValid <= 0, WlError <= 1.
- **Encoder:** LastWrId is the binary index of the single set bit. For a rejected wordline the encoder output is don't-care and is never captured.
- **Read decode:** each SrcRegN is decoded to a one-hot 16-bit readline. SrcDataN is the register selected by that readline, implemented as an AND-OR of readline with the array. The decoded readline is always exactly one-hot.
- **Bypass (BYPASS=1):** if the current Wordline is an accepted write to register k and SrcRegN == k, then SrcDataN = DstData in that same cycle. A rejected wordline never bypasses.
- **Shared reads:** both ports may read the same register, including the one being bypassed; both return the same value.
- **WlError:** cleared only by rst_n. Later valid writes proceed normally while it is set.

## Timing
- **Reset (rst_n low), asynchronous:** all registers = 0, WrValid = 0, LastWrId = 0, WlError = 0. SrcData1 and SrcData2 read 0 while reset is held (array cleared; bypass still applies if Wordline is accepted).
- **Reset mid-write:** an rst_n assertion in a cycle with an accepted Wordline wins; no write lands.
- **First write after reset:** the first rising edge with rst_n high accepts a write.
- **Write latency:** data is visible on a read port through the array in the cycle after the write edge. With BYPASS=1 it is visible in the write cycle itself.
- **Read latency:** 0 cycles (combinational from SrcRegN and the array).
- **WrValid / LastWrId:** update on the same edge as the array write.
- **WlError:** rises on the edge that ends the offending cycle.
- **Back-to-back writes to the same register:** the last one wins. WrValid stays high for both cycles, one pulse per accepted write.
- **Simultaneous write to k and read of k with BYPASS=0:** the read returns the pre-edge value.

## Test plan
- **Reset:** assert rst_n=0 mid-run after loading R5=16'hBEEF, then release. Required: SrcData1 with SrcReg1=5 reads 16'h0000; WrValid=0, LastWrId=0, WlError=0.
- **Sweep:** write each Ri = 16'hA000+i via Wordline = 1<<i over 16 cycles, then read all pairs (i, 15-i). Required: exact values returned; LastWrId follows i one cycle late; WrValid high for 16 consecutive cycles.
- **Bypass (BYPASS=1):** Wordline=16'h0080, DstData=16'h1234, SrcReg1=SrcReg2=7 in the same cycle. Required: both ports read 16'h1234 that cycle. With BYPASS=0: both read the old R7 that cycle and 16'h1234 the next.
- **Multi-hot:** R3=16'h0003, R9=16'h0009 preloaded, then Wordline=16'h0208, DstData=16'hFFFF. Required: R3 and R9 unchanged, WlError=1 next cycle and held, WrValid=0, LastWrId unchanged, no bypass.
- **Idle and recovery:** Wordline=16'h0000 for 3 cycles, then a valid write to R15=16'h8001 after an error. Required: no state change while idle; R15 written, LastWrId=4'hF, WlError stays 1.
- **Reset during write:** rst_n asserted in the same cycle as Wordline=16'h0001, DstData=16'h5555. Required: R0 = 0 after release, WrValid = 0.

Source files
------------

// File: rtl/wordline_regfile.sv
// 16-entry register file written through a one-hot wordline and read on two
// ports by register ID, with write-back status (valid pulse, index, sticky error).
module wordline_regfile #(
    parameter int DATA_W = 16,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       Wordline,
    input  logic [DATA_W-1:0] DstData,
    input  logic [3:0]        SrcReg1,
    input  logic [3:0]        SrcReg2,
    output logic [DATA_W-1:0] SrcData1,
    output logic [DATA_W-1:0] SrcData2,
    output logic              WrValid,
    output logic [3:0]        LastWrId,
    output logic              WlError
);

    logic [DATA_W-1:0] regs [16];
    logic              nonzero;
    logic              single;
    logic              accepted;
    logic              multi_hot;
    logic [3:0]        wr_id;
    logic [15:0]       rd_line1;
    logic [15:0]       rd_line2;
    logic [DATA_W-1:0] array_data1;
    logic [DATA_W-1:0] array_data2;
    logic              bypass1;
    logic              bypass2;

    // A value with exactly one set bit clears to zero when its lowest set bit is removed.
    always_comb begin
        nonzero   = (Wordline != 16'h0000);
        single    = ((Wordline & (Wordline - 16'h0001)) == 16'h0000);
        accepted  = nonzero && single;
        multi_hot = nonzero && !single;
    end

    always_comb begin
        wr_id = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (Wordline[i]) begin
                wr_id = wr_id | 4'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else if (accepted) begin
            for (int i = 0; i < 16; i++) begin
                if (Wordline[i]) begin
                    regs[i] <= DstData;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WrValid  <= 1'b0;
            LastWrId <= 4'h0;
            WlError  <= 1'b0;
        end else begin
            WrValid <= accepted;
            if (accepted) begin
                LastWrId <= wr_id;
            end
            if (multi_hot) begin
                WlError <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_line1 = 16'h0001 << SrcReg1;
        rd_line2 = 16'h0001 << SrcReg2;
    end

    // Read mux as AND-OR over the one-hot readlines.
    always_comb begin
        array_data1 = '0;
        array_data2 = '0;
        for (int i = 0; i < 16; i++) begin
            array_data1 = array_data1 | ({DATA_W{rd_line1[i]}} & regs[i]);
            array_data2 = array_data2 | ({DATA_W{rd_line2[i]}} & regs[i]);
        end
    end

    always_comb begin
        bypass1  = BYPASS && accepted && (wr_id == SrcReg1);
        bypass2  = BYPASS && accepted && (wr_id == SrcReg2);
        SrcData1 = bypass1 ? DstData : array_data1;
        SrcData2 = bypass2 ? DstData : array_data2;
    end

endmodule
